// File: rtl/iq_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iq_sched_pkg
// Brief    : Shared types and constants for the I/Q DAC scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package iq_sched_pkg;

    // Scheduler FSM encoding; 2'd3 is unused and recovers to idle.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PREFILL = 2'd1,
        S_STREAM  = 2'd2
    } state_t;

    // DAC code driven whenever no sample is being streamed.
    localparam logic [7:0] c_MIDSCALE = 8'h80;

    // One FIFO entry holds {I, Q}.
    localparam int c_PAIR_W = 16;

endpackage
`default_nettype wire

// File: rtl/iq_pair_fifo.sv
`default_nettype none
// ============================================================================
// Module   : iq_pair_fifo
// Brief    : Synchronous FIFO of {I,Q} pairs with flush and overflow pulse.
//            Pointers carry one extra wrap bit so count = wptr - rptr.
// Revision : 1.0 - initial release
// ============================================================================
module iq_pair_fifo
    import iq_sched_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = c_PAIR_W
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset_n,
    input  logic                     i_Flush,
    input  logic                     i_Push,
    input  logic [WIDTH-1:0]         i_Push_Data,
    input  logic                     i_Pop,
    output logic [WIDTH-1:0]         o_Pop_Data,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic [$clog2(DEPTH):0]   o_Count,
    output logic                     o_Overflow
);

    localparam int                c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_DEPTH = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wptr;
    logic [c_AW:0]    r_rptr;
    logic             w_wr;
    logic             w_rd;

    assign o_Count    = r_wptr - r_rptr;
    assign o_Full     = (o_Count == c_DEPTH);
    assign o_Empty    = (r_wptr == r_rptr);
    assign o_Pop_Data = r_mem[r_rptr[c_AW-1:0]];

    // A simultaneous pop frees the slot, so a push while full is still taken.
    assign w_wr       = i_Push && !i_Flush && (!o_Full || i_Pop);
    assign w_rd       = i_Pop  && !i_Flush && !o_Empty;
    assign o_Overflow = i_Push && !i_Flush && o_Full && !i_Pop;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge i_Clock) begin
        if (w_wr) begin
            r_mem[r_wptr[c_AW-1:0]] <= i_Push_Data;
        end
    end

    // Read/write pointers; flush empties the FIFO in one cycle.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_Flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/iq_dac_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : iq_dac_scheduler
// Brief    : Pairs UART bytes into I/Q samples, buffers them and releases one
//            pair per sample period to the DACs; mid-scale when idle.
// Revision : 1.0 - initial release
// ============================================================================
module iq_dac_scheduler
    import iq_sched_pkg::*;
#(
    parameter int         CLKS_PER_SAMPLE = 100,
    parameter int         FIFO_DEPTH      = 16,
    parameter int         PREFILL         = 4,
    parameter int         GAP_TIMEOUT     = 1000,
    parameter logic [7:0] MIDSCALE        = c_MIDSCALE
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset_n,
    input  logic                          i_Rx_DV,
    input  logic [7:0]                    i_Rx_Byte,
    input  logic                          i_Enable,
    output logic [7:0]                    o_I_Data,
    output logic [7:0]                    o_Q_Data,
    output logic                          o_Sample_Strobe,
    output logic                          o_Underflow,
    output logic                          o_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fill,
    output logic [1:0]                    o_State,
    output logic                          o_I_LED,
    output logic                          o_Q_LED
);

    localparam int                  c_FILL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_FILL_W-1:0] c_PREFILL_N = c_FILL_W'(PREFILL);
    localparam logic [15:0]         c_TICK_LAST = 16'(CLKS_PER_SAMPLE - 1);
    localparam logic [15:0]         c_GAP_LAST  = 16'(GAP_TIMEOUT - 1);

    logic                r_en_meta;
    logic                r_en_s;
    logic                r_phase_q;
    logic [7:0]          r_i_byte;
    logic [15:0]         r_gap;
    logic [15:0]         r_tick;
    state_t              r_state;

    logic                w_push;
    logic                w_pop;
    logic                w_flush;
    logic                w_full;
    logic                w_empty;
    logic                w_fifo_ovf;
    logic [c_PAIR_W-1:0] w_head;

    assign w_push  = r_en_s && r_phase_q && i_Rx_DV;
    assign w_pop   = r_en_s && (r_state == S_STREAM) && (r_tick == c_TICK_LAST) && !w_empty;
    // Disable discards everything buffered; the unused encoding flushes too.
    assign w_flush = !r_en_s || (r_state == state_t'(2'd3));
    assign o_State = r_state;

    iq_pair_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_PAIR_W)
    ) u_fifo (
        .i_Clock     (i_Clock),
        .i_Reset_n   (i_Reset_n),
        .i_Flush     (w_flush),
        .i_Push      (w_push),
        .i_Push_Data ({r_i_byte, i_Rx_Byte}),
        .i_Pop       (w_pop),
        .o_Pop_Data  (w_head),
        .o_Full      (w_full),
        .o_Empty     (w_empty),
        .o_Count     (o_Fill),
        .o_Overflow  (w_fifo_ovf)
    );

    // Two-flop synchroniser for the asynchronous enable level.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_en_meta <= 1'b0;
            r_en_s    <= 1'b0;
        end else begin
            r_en_meta <= i_Enable;
            r_en_s    <= r_en_meta;
        end
    end

    // Byte pairing with gap timeout that re-aligns to the I byte.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_phase_q <= 1'b0;
            r_i_byte  <= '0;
            r_gap     <= '0;
            o_I_LED   <= 1'b0;
            o_Q_LED   <= 1'b0;
        end else if (!r_en_s) begin
            r_phase_q <= 1'b0;
            r_gap     <= '0;
        end else if (!r_phase_q) begin
            if (i_Rx_DV) begin
                r_i_byte  <= i_Rx_Byte;
                r_phase_q <= 1'b1;
                r_gap     <= '0;
                o_I_LED   <= ~o_I_LED;
            end
        end else if (i_Rx_DV) begin
            r_phase_q <= 1'b0;
            o_Q_LED   <= ~o_Q_LED;
        end else if (r_gap == c_GAP_LAST) begin
            r_phase_q <= 1'b0;
            r_gap     <= '0;
        end else begin
            r_gap <= r_gap + 16'd1;
        end
    end

    // Scheduler FSM: sample-period counter, registered DAC outputs and flags.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state         <= S_IDLE;
            r_tick          <= '0;
            o_I_Data        <= MIDSCALE;
            o_Q_Data        <= MIDSCALE;
            o_Sample_Strobe <= 1'b0;
            o_Underflow     <= 1'b0;
            o_Overflow      <= 1'b0;
        end else begin
            o_Sample_Strobe <= 1'b0;
            if (w_fifo_ovf) o_Overflow <= 1'b1;
            if (!r_en_s) begin
                r_state     <= S_IDLE;
                r_tick      <= '0;
                o_I_Data    <= MIDSCALE;
                o_Q_Data    <= MIDSCALE;
                o_Underflow <= 1'b0;
                o_Overflow  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_tick   <= '0;
                        o_I_Data <= MIDSCALE;
                        o_Q_Data <= MIDSCALE;
                        r_state  <= S_PREFILL;
                    end
                    S_PREFILL: begin
                        if (o_Fill >= c_PREFILL_N) begin
                            r_state <= S_STREAM;
                            r_tick  <= '0;
                        end
                    end
                    S_STREAM: begin
                        if (r_tick == c_TICK_LAST) begin
                            r_tick          <= '0;
                            o_Sample_Strobe <= 1'b1;
                            if (!w_empty) begin
                                o_I_Data <= w_head[15:8];
                                o_Q_Data <= w_head[7:0];
                            end else begin
                                o_Underflow <= 1'b1;
                                o_I_Data    <= MIDSCALE;
                                o_Q_Data    <= MIDSCALE;
                                r_state     <= S_PREFILL;
                            end
                        end else begin
                            r_tick <= r_tick + 16'd1;
                        end
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_tick   <= '0;
                        o_I_Data <= MIDSCALE;
                        o_Q_Data <= MIDSCALE;
                    end
                endcase
            end
        end
    end

    // Full is visible through o_Fill; kept as a named net for debug probing.
    logic w_full_unused;
    assign w_full_unused = w_full;

endmodule
`default_nettype wire

// File: tb/tb_iq_dac_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_iq_dac_scheduler
// Brief    : Self-checking bench; expected DAC pairs are queued as bytes are
//            sent and checked by a strobe monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iq_dac_scheduler;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv    = 1'b0;
    logic [7:0] rxb   = 8'h00;
    logic       en    = 1'b0;
    logic [7:0] i_data, q_data;
    logic       strobe, underflow, overflow, i_led, q_led;
    logic [4:0] fill;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q [$];
    logic [15:0] m_exp;

    iq_dac_scheduler dut (
        .i_Clock         (clk),
        .i_Reset_n       (rst_n),
        .i_Rx_DV         (dv),
        .i_Rx_Byte       (rxb),
        .i_Enable        (en),
        .o_I_Data        (i_data),
        .o_Q_Data        (q_data),
        .o_Sample_Strobe (strobe),
        .o_Underflow     (underflow),
        .o_Overflow      (overflow),
        .o_Fill          (fill),
        .o_State         (state),
        .o_I_LED         (i_led),
        .o_Q_LED         (q_led)
    );

    always #50 clk = ~clk;

    // Strobe monitor: every strobe must match the oldest expected pair.
    always @(negedge clk) begin
        if (rst_n && strobe) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL strobe_unexpected: got I=%h Q=%h, required no strobe", i_data, q_data);
            end else begin
                m_exp = exp_q.pop_front();
                if ({i_data, q_data} !== m_exp) begin
                    bad++;
                    $display("FAIL sample_pair: got %h%h, required %h", i_data, q_data, m_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        dv  = 1'b1;
        rxb = b;
        tick();
        dv  = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input bit expect_out);
        send_byte(a);
        if (expect_out) exp_q.push_back({a, b});
        send_byte(b);
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: %0d pairs still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        total++;
        if ({i_data, q_data} !== 16'h8080) begin
            bad++; $display("FAIL reset_outputs: got %h%h, required 8080", i_data, q_data);
        end
        total++;
        if ({fill, state} !== 7'd0) begin
            bad++; $display("FAIL reset_fill_state: got fill=%0d state=%0d, required 0/0", fill, state);
        end
        total++;
        if ({strobe, underflow, overflow, i_led, q_led} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b, required 00000", {strobe, underflow, overflow, i_led, q_led});
        end
    endtask

    task automatic test_stream();
        int n;
        en = 1'b1;
        repeat (5) tick();
        total++;
        if (state !== 2'd1) begin
            bad++; $display("FAIL enter_prefill: got state=%0d, required 1", state);
        end
        send_byte(8'd10);
        total++;
        if ({i_led, q_led} !== 2'b10) begin
            bad++; $display("FAIL led_after_i: got %b, required 10", {i_led, q_led});
        end
        exp_q.push_back({8'd10, 8'd20});
        send_byte(8'd20);
        total++;
        if ({i_led, q_led} !== 2'b11) begin
            bad++; $display("FAIL led_after_q: got %b, required 11", {i_led, q_led});
        end
        send_pair(8'd30, 8'd40, 1'b1);
        send_pair(8'd50, 8'd60, 1'b1);
        send_pair(8'd70, 8'd80, 1'b1);
        total++;
        if (fill !== 5'd4 || state !== 2'd1) begin
            bad++; $display("FAIL prefill_count: got fill=%0d state=%0d, required 4/1", fill, state);
        end
        tick();
        total++;
        if (state !== 2'd2) begin
            bad++; $display("FAIL enter_stream: got state=%0d, required 2", state);
        end
        n = 0;
        while (!strobe && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (n !== 100) begin
            bad++; $display("FAIL first_strobe_latency: got %0d clocks, required 100", n);
        end
        wait_drain(400, "stream");
        exp_q.push_back(16'h8080);
        wait_drain(200, "underflow");
        total++;
        if (underflow !== 1'b1 || state !== 2'd1 || {i_data, q_data} !== 16'h8080) begin
            bad++; $display("FAIL underflow: got uf=%b state=%0d out=%h%h, required 1/1/8080", underflow, state, i_data, q_data);
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 17; k++) begin
            send_pair(8'(k + 8'h20), 8'(k + 8'hA0), k < 16);
        end
        total++;
        if (fill !== 5'd16 || overflow !== 1'b1) begin
            bad++; $display("FAIL overflow: got fill=%0d ovf=%b, required 16/1", fill, overflow);
        end
        total++;
        if (underflow !== 1'b1) begin
            bad++; $display("FAIL underflow_sticky: got %b, required 1", underflow);
        end
        exp_q.push_back(16'h8080);
        wait_drain(2500, "overflow_drain");
        total++;
        if (state !== 2'd1 || fill !== 5'd0) begin
            bad++; $display("FAIL after_drain: got state=%0d fill=%0d, required 1/0", state, fill);
        end
    endtask

    task automatic test_gap();
        send_byte(8'h55);
        repeat (1005) tick();
        send_pair(8'h11, 8'h22, 1'b1);
        total++;
        if (fill !== 5'd1) begin
            bad++; $display("FAIL gap_realign_fill: got %0d, required 1", fill);
        end
        send_pair(8'h33, 8'h44, 1'b1);
        send_pair(8'h66, 8'h77, 1'b1);
        send_pair(8'h99, 8'hAA, 1'b1);
        exp_q.push_back(16'h8080);
        wait_drain(800, "gap");
    endtask

    task automatic test_disable();
        int n;
        logic [1:0] leds;
        send_pair(8'h01, 8'h02, 1'b1);
        send_pair(8'h03, 8'h04, 1'b1);
        send_pair(8'h05, 8'h06, 1'b1);
        send_pair(8'h07, 8'h08, 1'b1);
        tick();
        total++;
        if (state !== 2'd2) begin
            bad++; $display("FAIL disable_setup: got state=%0d, required 2", state);
        end
        send_byte(8'h5A);
        repeat (20) tick();
        en = 1'b0;
        n = 0;
        while (state !== 2'd0 && n < 10) begin
            tick();
            n++;
        end
        exp_q.delete();
        total++;
        if (n > 3) begin
            bad++; $display("FAIL disable_latency: got %0d clocks, required <=3", n);
        end
        total++;
        if ({i_data, q_data} !== 16'h8080 || {underflow, overflow} !== 2'b00 || fill !== 5'd0) begin
            bad++; $display("FAIL disable_idle: got out=%h%h uf=%b ovf=%b fill=%0d, required 8080/0/0/0",
                            i_data, q_data, underflow, overflow, fill);
        end
        leds = {i_led, q_led};
        for (int k = 0; k < 4; k++) send_byte(8'(8'hC0 + k));
        repeat (3) tick();
        total++;
        if (fill !== 5'd0 || {i_led, q_led} !== leds || state !== 2'd0) begin
            bad++; $display("FAIL disabled_ignore: got fill=%0d leds=%b state=%0d, required 0/%b/0",
                            fill, {i_led, q_led}, state, leds);
        end
    endtask

    task automatic test_reset_midstream();
        int n;
        en = 1'b1;
        repeat (4) tick();
        send_pair(8'hE1, 8'hE2, 1'b1);
        send_pair(8'hE3, 8'hE4, 1'b1);
        send_pair(8'hE5, 8'hE6, 1'b1);
        send_pair(8'hE7, 8'hE8, 1'b1);
        n = 0;
        while (exp_q.size() > 3 && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() !== 3) begin
            bad++; $display("FAIL midstream_setup: got %0d pending, required 3", exp_q.size());
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({i_data, q_data} !== 16'h8080 || fill !== 5'd0 || state !== 2'd0) begin
            bad++; $display("FAIL async_reset: got out=%h%h fill=%0d state=%0d, required 8080/0/0",
                            i_data, q_data, fill, state);
        end
        exp_q.delete();
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_overflow();
        test_gap();
        test_disable();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(100 * 60000);
        $display("FAIL global_timeout: simulation exceeded 60000 clocks, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
